// File: rtl/matrix_pkg.sv
// Shared types and constants for the 8x8 dot-matrix scan capture block.
package matrix_pkg;

    localparam int MX_ROWS = 8;
    localparam int MX_COLS = 8;

    typedef logic [2:0] row_idx_t;
    typedef logic [7:0] row_bits_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/matrix_scan_capture_if.sv
// Scan-bus and readout signals of matrix_scan_capture; master drives the
// matrix pins and readout index, slave is the capture monitor.
interface matrix_scan_capture_if #(
    parameter int FCNT_W = 16
) ();
    import matrix_pkg::*;

    row_bits_t           row;
    row_bits_t           R_col;
    row_idx_t            rd_row;
    row_bits_t           rd_data;
    logic                frame_done;
    logic [FCNT_W-1:0]   frame_cnt;
    logic                err;

    modport master (
        output row, R_col, rd_row,
        input  rd_data, frame_done, frame_cnt, err
    );

    modport slave (
        input  row, R_col, rd_row,
        output rd_data, frame_done, frame_cnt, err
    );

endinterface

// File: rtl/onehot_row_decode.sv
// Maps an active-low one-hot row strobe to {valid, illegal, idx}.
// All ones is blanking; two or more low bits is illegal and never valid.
module onehot_row_decode
    import matrix_pkg::*;
(
    input  row_bits_t row,
    output logic      valid,
    output logic      illegal,
    output row_idx_t  idx
);

    logic [3:0] low_cnt;

    always_comb begin
        low_cnt = '0;
        idx     = '0;
        for (int i = 0; i < MX_ROWS; i++) begin
            if (!row[i]) begin
                low_cnt = low_cnt + 4'd1;
                idx     = row_idx_t'(i);
            end
        end
        valid   = (low_cnt == 4'd1);
        illegal = (low_cnt > 4'd1);
    end

endmodule

// File: rtl/matrix_scan_capture.sv
// Passive monitor that rebuilds the displayed 8x8 frame from the row/column scan bus.
// Build option SCAN_CAPTURE_DBL_BUF_EN: readout shows only completed frames.
module matrix_scan_capture
    import matrix_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int FCNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_scan_capture_if.slave bus
);

    localparam logic [1:0] IDLE       = ST_IDLE;
    localparam logic [1:0] SETTLE     = ST_SETTLE;
    localparam logic [1:0] HOLD       = ST_HOLD;
    localparam logic [8:0] STABLE_LIM = 9'(STABLE_CYC);

    row_bits_t         s_row_reg;
    row_bits_t         s_col_reg;
    logic              dec_valid;
    logic              dec_illegal;
    row_idx_t          dec_idx;

    logic [1:0]        state_reg, state_next;
    logic [7:0]        stab_cnt_reg, stab_cnt_next;
    row_idx_t          p_row_reg, p_row_next;
    row_bits_t         p_col_reg, p_col_next;
    logic              sample_match;
    logic              load_new;
    logic              capture;

    row_bits_t         seen_reg, seen_next;
    logic              seen_full;
    logic              frame_done_reg;
    logic [FCNT_W-1:0] frame_cnt_reg;
    logic              err_reg;
    row_bits_t         rd_data_reg;
    row_bits_t         visible [MX_ROWS];

    // Same-clock source: a single register stage aligns the pins, no synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_row_reg <= '1;
            s_col_reg <= '0;
        end else begin
            s_row_reg <= bus.row;
            s_col_reg <= bus.R_col;
        end
    end

    onehot_row_decode u_decode (
        .row     (s_row_reg),
        .valid   (dec_valid),
        .illegal (dec_illegal),
        .idx     (dec_idx)
    );

    assign sample_match = dec_valid && (dec_idx == p_row_reg) && (s_col_reg == p_col_reg);

    always_comb begin
        state_next    = state_reg;
        stab_cnt_next = stab_cnt_reg;
        p_row_next    = p_row_reg;
        p_col_next    = p_col_reg;
        load_new      = 1'b0;
        capture       = 1'b0;

        case (state_reg)
            IDLE: begin
                load_new = dec_valid;
            end
            SETTLE: begin
                if (sample_match) begin
                    stab_cnt_next = stab_cnt_reg + 8'd1;
                    if ({1'b0, stab_cnt_reg} + 9'd1 >= STABLE_LIM) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end else if (dec_valid) begin
                    load_new = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (!sample_match) begin
                    if (dec_valid) load_new = 1'b1;
                    else           state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new pattern counts as its first stable sample; with a threshold of 1 it is taken at once.
        if (load_new) begin
            stab_cnt_next = 8'd1;
            p_row_next    = dec_idx;
            p_col_next    = s_col_reg;
            if (STABLE_CYC <= 1) begin
                capture    = 1'b1;
                state_next = HOLD;
            end else begin
                state_next = SETTLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            stab_cnt_reg <= '0;
            p_row_reg    <= '0;
            p_col_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            stab_cnt_reg <= stab_cnt_next;
            p_row_reg    <= p_row_next;
            p_col_reg    <= p_col_next;
        end
    end

    // A capture coinciding with the end-of-frame clear starts the next mask with its own bit.
    assign seen_full = (seen_reg == '1);

    always_comb begin
        seen_next = seen_full ? '0 : seen_reg;
        if (capture) seen_next[dec_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seen_reg <= '0;
        else      seen_reg <= seen_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < MX_ROWS; gi = gi + 1) begin : g_row
            row_bits_t cap_row_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    cap_row_reg <= '0;
                else if (capture && (dec_idx == row_idx_t'(gi)))
                    cap_row_reg <= s_col_reg;
            end

`ifdef SCAN_CAPTURE_DBL_BUF_EN
            row_bits_t vis_row_reg;

            // Shadow is complete when seen is full; publish it on the frame_done edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)           vis_row_reg <= '0;
                else if (seen_full) vis_row_reg <= cap_row_reg;
            end

            assign visible[gi] = vis_row_reg;
`else
            assign visible[gi] = cap_row_reg;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_reg    <= '0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            rd_data_reg    <= visible[bus.rd_row];
            frame_done_reg <= seen_full;
            frame_cnt_reg  <= frame_cnt_reg + FCNT_W'(seen_full);
            err_reg        <= err_reg | dec_illegal;
        end
    end

    assign bus.rd_data    = rd_data_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.frame_cnt  = frame_cnt_reg;
    assign bus.err        = err_reg;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Self-checking bench for matrix_scan_capture: scan tables, readout and frame scoreboards.
// Expectations follow SCAN_CAPTURE_DBL_BUF_EN when the build defines it.
module tb_matrix_scan_capture;
    import matrix_pkg::*;

    localparam int STABLE = 4;
    localparam int FCW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matrix_scan_capture_if #(.FCNT_W(FCW)) bus ();

    matrix_scan_capture #(
        .STABLE_CYC (STABLE),
        .FCNT_W     (FCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        row_idx_t  row;
        row_bits_t exp;
    } rd_exp_t;

    typedef struct {
        row_bits_t pat;
        row_idx_t  idx;
        row_bits_t col;
        int        hold;
        bit        cap;
    } scan_vec_t;

    rd_exp_t          rd_q[$];
    logic [FCW-1:0]   fd_q[$];
    scan_vec_t        vecs[$];

    row_bits_t        exp_shadow [8];
    row_bits_t        exp_vis    [8];
    row_bits_t        exp_mask;
    logic [FCW-1:0]   exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic row_bits_t row_pat(input row_idx_t i);
        row_bits_t p;
        p    = '1;
        p[i] = 1'b0;
        return p;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            exp_shadow[i] = '0;
            exp_vis[i]    = '0;
        end
        exp_mask = '0;
        exp_cnt  = '0;
    endfunction

    function automatic void model_capture(input row_idx_t idx, input row_bits_t col);
        exp_shadow[idx] = col;
`ifndef SCAN_CAPTURE_DBL_BUF_EN
        exp_vis[idx] = col;
`endif
        exp_mask[idx] = 1'b1;
        if (exp_mask == 8'hFF) begin
            exp_mask = '0;
            exp_cnt  = exp_cnt + 1'b1;
`ifdef SCAN_CAPTURE_DBL_BUF_EN
            for (int i = 0; i < 8; i++) exp_vis[i] = exp_shadow[i];
`endif
            fd_q.push_back(exp_cnt);
        end
    endfunction

    task automatic scan(input row_bits_t pat, input row_idx_t idx, input row_bits_t col,
                        input int hold, input bit cap);
        bus.row   = pat;
        bus.R_col = col;
        if (cap) model_capture(idx, col);
        tick(hold);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++)
            scan(vecs[i].pat, vecs[i].idx, vecs[i].col, vecs[i].hold, vecs[i].cap);
        vecs.delete();
    endtask

    task automatic add(input row_bits_t pat, input row_idx_t idx, input row_bits_t col,
                       input int hold, input bit cap);
        vecs.push_back('{pat: pat, idx: idx, col: col, hold: hold, cap: cap});
    endtask

    task automatic read_row(input row_idx_t r);
        bus.rd_row = r;
        rd_q.push_back('{row: r, exp: exp_vis[r]});
        tick();
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++) read_row(row_idx_t'(r));
    endtask

    // Output monitor: pops one readout per edge and one frame_cnt per frame_done pulse.
    logic    prev_fd = 1'b0;
    rd_exp_t mon_e;
    bit      mon_have;
    always @(posedge clk) begin
        mon_have = (rd_q.size() > 0);
        if (mon_have) mon_e = rd_q.pop_front();
        #1;
        if (mon_have) begin
            $display("read row %0d data %02h expected %02h", mon_e.row, bus.rd_data, mon_e.exp);
            check($sformatf("rd_data[%0d]", mon_e.row), bus.rd_data, mon_e.exp);
        end
        if (bus.frame_done === 1'b1) begin
            $display("frame_done frame_cnt %0d", bus.frame_cnt);
            check("frame_done_width", prev_fd, 1'b0);
            if (fd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_done_unexpected: got pulse with frame_cnt %0d, expected none",
                         bus.frame_cnt);
            end else begin
                check("frame_cnt_at_done", bus.frame_cnt, fd_q.pop_front());
            end
        end
        prev_fd = bus.frame_done;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.row    = 8'hFF;
        bus.R_col  = '0;
        bus.rd_row = '0;
        model_reset();

        // Reset state
        tick(2);
        check("reset_rd_data", bus.rd_data, 8'h00);
        check("reset_frame_done", bus.frame_done, 1'b0);
        check("reset_frame_cnt", bus.frame_cnt, 4'h0);
        check("reset_err", bus.err, 1'b0);
        rst = 1'b1;
        tick(2);

        // Full frame: rows 0..6 from the table, row 7 by hand to time frame_done
        add(row_pat(0), 3'd0, 8'h81, 10, 1);
        add(row_pat(1), 3'd1, 8'h42, 10, 1);
        add(row_pat(2), 3'd2, 8'h24, 10, 1);
        add(row_pat(3), 3'd3, 8'h18, 10, 1);
        add(row_pat(4), 3'd4, 8'h18, 10, 1);
        add(row_pat(5), 3'd5, 8'h24, 10, 1);
        add(row_pat(6), 3'd6, 8'h42, 10, 1);
        run_table();
        bus.row   = row_pat(7);
        bus.R_col = 8'h81;
        model_capture(3'd7, 8'h81);
        tick(5);
        check("frame_done_before_edge", bus.frame_done, 1'b0);
        tick();
        check("frame_done_pulse", bus.frame_done, 1'b1);
        tick();
        check("frame_done_after_pulse", bus.frame_done, 1'b0);
        tick(3);
        bus.row = 8'hFF;
        tick(3);
        check("frame_cnt_one_frame", bus.frame_cnt, exp_cnt);
        check("fd_q_drained_frame", fd_q.size(), 0);
        read_all();

        // Glitch rejection and column-change restart
        add(8'hFE,       3'd0, 8'h55, 3,  0);
        add(8'hFD,       3'd1, 8'hAA, 10, 1);
        add(8'hFF,       3'd0, 8'h00, 3,  0);
        add(row_pat(2),  3'd2, 8'h33, 2,  0);
        add(row_pat(2),  3'd2, 8'h44, 3,  0);
        add(8'hFF,       3'd0, 8'h00, 3,  0);
        run_table();
        read_row(3'd0);
        read_row(3'd1);
        read_row(3'd2);

        // Illegal pattern: err after the second edge, no capture
        bus.row   = 8'hFC;
        bus.R_col = 8'hFF;
        tick();
        check("err_first_edge", bus.err, 1'b0);
        tick();
        check("err_second_edge", bus.err, 1'b1);
        tick(3);
        bus.row = 8'hFF;
        tick(3);
        check("err_sticky_blank", bus.err, 1'b1);
        read_row(3'd0);
        read_row(3'd1);

        // Overwrite before completion
        add(row_pat(3), 3'd3, 8'h0F, 6, 1);
        add(row_pat(3), 3'd3, 8'hF0, 6, 1);
        for (int r = 0; r < 8; r++)
            if (r != 3) add(row_pat(row_idx_t'(r)), row_idx_t'(r), 8'(8'h10 + r), 6, 1);
        add(8'hFF, 3'd0, 8'h00, 4, 0);
        run_table();
        check("err_sticky_legal", bus.err, 1'b1);
        check("frame_cnt_overwrite", bus.frame_cnt, exp_cnt);
        check("fd_q_drained_overwrite", fd_q.size(), 0);
        read_row(3'd3);
        read_all();

        // Reset mid-frame
        for (int r = 0; r < 5; r++)
            add(row_pat(row_idx_t'(r)), row_idx_t'(r), 8'(8'hA0 + r), 6, 1);
        add(8'hFF, 3'd0, 8'h00, 2, 0);
        run_table();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        check("midrst_err", bus.err, 1'b0);
        check("midrst_frame_cnt", bus.frame_cnt, 4'h0);
        for (int r = 5; r < 8; r++)
            add(row_pat(row_idx_t'(r)), row_idx_t'(r), 8'(8'hB0 + r), 6, 1);
        add(8'hFF, 3'd0, 8'h00, 4, 0);
        run_table();
        read_all();
        check("midrst_frame_cnt_after", bus.frame_cnt, 4'h0);

        // Sixteen frames wrap the 4-bit counter
        for (int f = 0; f < 16; f++)
            for (int r = 0; r < 8; r++)
                scan(row_pat(row_idx_t'(r)), row_idx_t'(r), 8'(f * 16 + r + 1), 5, 1);
        bus.row = 8'hFF;
        tick(4);
        check("wrap_frame_cnt", bus.frame_cnt, exp_cnt);
        check("fd_q_drained_wrap", fd_q.size(), 0);
        read_all();

        // Partial frame after wrap: double buffer keeps the last complete frame visible
        for (int r = 0; r < 4; r++)
            scan(row_pat(row_idx_t'(r)), row_idx_t'(r), 8'(8'hC0 + r), 5, 1);
        bus.row = 8'hFF;
        tick(4);
        read_all();

        check("final_rd_q_empty", rd_q.size(), 0);
        check("final_fd_q_empty", fd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan_capture.md
# matrix_scan_capture

Passive monitor for the 8x8 LED dot-matrix scan bus. It samples the row strobe and the red column drive produced by the display driver and reconstructs the displayed frame into an internal 8x8 bitmap. The bitmap can be read back one row at a time, and a pulse marks each completed frame. The block sits on the driver's output pins, in the bench or on-chip, and gives self-checking tests and debug logic a readable image of what the matrix is actually showing.

## Interface
- STABLE_CYC, 4, consecutive identical samples required before a row is accepted (legal range 1..255).
- FCNT_W, 16, width of the frame counter.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- row  in  8  row strobe: one-hot active-low; bit i low means row i is lit.
- R_col  in  8  column drive for the strobed row: active-high, bit j is column j.
- rd_row  in  3  readout row index.
- rd_data  out  8  captured bitmap of row rd_row.
- frame_done  out  1  one-cycle pulse when all 8 rows have been captured.
- frame_cnt  out  FCNT_W  count of completed frames; wraps.
- err  out  1  sticky flag: an illegal row pattern was seen.

## Operation
- Input stage: row and R_col are registered once (s_row, s_col) every cycle. The source is on the same clock, so there is no synchronizer.
- Row decode:
  - Exactly one bit of s_row low gives valid=1 and idx = position of that bit.
  - All ones means blanking (valid=0).
  - Two or more bits low is illegal: err is set and the sample is treated as blanking.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: on a valid sample, load stab_cnt=1 and record p_row/p_col. Go to SETTLE, or write immediately if STABLE_CYC=1.
  - SETTLE: a sample equal to {p_row,p_col} increments stab_cnt. When stab_cnt reaches STABLE_CYC, perform a capture and go to HOLD.
  - SETTLE: a different valid sample restarts counting with stab_cnt=1 on the new pattern.
  - SETTLE: blanking or an illegal sample returns to IDLE.
  - HOLD: stays while the sample equals {p_row,p_col}. Any change goes to IDLE, or re-enters SETTLE with stab_cnt=1 if the new sample is valid.
- Capture:
  - Write frame[idx] <= p_col and set seen[idx].
  - Capturing the same row again before the frame completes overwrites the data; seen is unchanged.
- Frame completion:
  - The cycle after seen becomes 8'hFF: frame_done=1, frame_cnt increments (wrapping from max to 0), and seen clears.
  - A capture landing in the same cycle as the clear sets only its own bit in the new mask.
- Readout: rd_data <= visible[rd_row], registered.
- Reset mid-operation:
  - Returns the FSM to IDLE.
  - Clears frame, seen, frame_cnt and err.
  - The partial frame is discarded.

## Timing
- Reset values: rd_data=0, frame_done=0, frame_cnt=0, err=0. The state is IDLE and the bitmap is all zeros.
- Capture latency: the write occurs at the clock edge where the (STABLE_CYC)th identical registered sample is seen. That is STABLE_CYC+1 edges after the pattern first appears on the pins.
- frame_done: asserted 1 cycle after the completing capture edge, for exactly 1 cycle.
- rd_data: reflects rd_row and bitmap contents with 1-cycle latency. A read of a row in the same cycle as its write returns the old value.
- err: set 2 edges after an illegal pattern appears on the pins; cleared only by rst.

## Configuration
- SCAN_CAPTURE_DBL_BUF_EN defined:
  - Captures go to a shadow bitmap.
  - On the frame_done cycle the shadow is copied into the visible bitmap, so readout only ever shows complete frames.
  - Before the first frame completes, visible reads all zeros.
- Not defined: a single bitmap; captures are immediately visible to readout.

## Structure
- Package matrix_pkg holds:
  - constants MX_ROWS=8 and MX_COLS=8;
  - typedef row_idx_t (3 bits);
  - typedef row_bits_t (8 bits);
  - the FSM state enum.
- One sub-module, onehot_row_decode: combinational mapping of s_row to {valid, illegal, idx}. It is reused by the display driver's own assertions.

## Test plan
- Full frame scan: scan rows 0..7 with R_col=8'h81,8'h42,8'h24,8'h18,8'h18,8'h24,8'h42,8'h81, each held 10 cycles with STABLE_CYC=4. Expect rd_data for rows 0..7 to match, one frame_done pulse, and frame_cnt=1.
- Glitch rejection: hold row=8'hFE for 3 cycles, then 8'hFD for 10 cycles. Expect row 0 not written and row 1 captured. Separately, an R_col change after 2 cycles restarts the count.
- Illegal pattern: row=8'hFC for 5 cycles. Expect err=1 from the second edge onward and no capture; err stays 1 through later legal scans until rst.
- Overwrite before completion: capture row 3=8'h0F, then row 3=8'hF0, then rows 0,1,2,4..7. Expect exactly one frame_done and rd_row=3 giving 8'hF0.
- Reset mid-frame: capture rows 0..4, then pulse rst low for 1 cycle, then scan rows 5..7. Expect no frame_done, rd_data=0 for rows 0..4, and frame_cnt=0.
- Wrap and double buffer (FCNT_W=4): after 16 frames expect frame_cnt=0. With SCAN_CAPTURE_DBL_BUF_EN, the visible bitmap stays at the previous frame until the new frame_done.
